// File: rtl/cve2_obi_sram_resp_if.sv
// OBI-style request/response bus between a CVE2 initiator and the SRAM responder.
interface cve2_obi_sram_resp_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/cve2_obi_sram_resp.sv
// Single-port SRAM responder for the CVE2 OBI data/instruction port: optional grant
// wait states, byte-masked writes, word reads, one-cycle in-order responses.
module cve2_obi_sram_resp #(
  parameter int unsigned Depth      = 1024,
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int unsigned WaitStates = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cve2_obi_sram_resp_if.slave  bus
);

  localparam int unsigned IdxW    = $clog2(Depth);
  localparam int unsigned AddrLsb = IdxW + 2;
  localparam int unsigned CntW    = 4;
  localparam int unsigned NumBe   = 4;
  localparam logic [CntW-1:0] WaitMax = CntW'(WaitStates);

  logic [CntW-1:0] wait_cnt;
  logic [31:0]     mem [Depth];
  logic            gnt_c;
  logic            in_range_c;
  logic [IdxW-1:0] idx_c;
  logic            unused_addr;

  // BaseAddr is aligned to the array size, so the range test is a tag compare
  // and the word index is just the address bits below the tag.
  assign in_range_c  = (bus.addr[31:AddrLsb] == BaseAddr[31:AddrLsb]);
  assign idx_c       = bus.addr[AddrLsb-1:2];
  assign unused_addr = ^bus.addr[1:0];

  assign gnt_c   = bus.req && (wait_cnt == WaitMax) && !rst_i;
  assign bus.gnt = gnt_c;

  // Wait counter restarts after every grant and whenever the request drops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (!bus.req || gnt_c) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + CntW'(1);
    end
  end

  // Response registers: one-cycle pulse after each grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= gnt_c;
      if (gnt_c) begin
        bus.err   <= !in_range_c;
        bus.rdata <= (in_range_c && !bus.we) ? mem[idx_c] : 32'h0;
      end else begin
        bus.err   <= 1'b0;
        bus.rdata <= '0;
      end
    end
  end

  // Array is deliberately not reset; gnt_c already masks writes during reset.
  always_ff @(posedge clk_i) begin
    if (gnt_c && bus.we && in_range_c) begin
      for (int unsigned b = 0; b < NumBe; b++) begin
        if (bus.be[b]) begin
          mem[idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_cve2_obi_sram_resp.sv
// Directed bench for cve2_obi_sram_resp: scoreboard of expected responses on a
// zero-wait instance plus cycle-exact grant checks on a two-wait-state instance.
module tb_cve2_obi_sram_resp;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  resp_t q[$];
  resp_t mon_e;

  cve2_obi_sram_resp_if ifc0();
  cve2_obi_sram_resp_if ifc2();

  cve2_obi_sram_resp #(.Depth(1024), .BaseAddr(32'h0), .WaitStates(0)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc0)
  );

  cve2_obi_sram_resp #(.Depth(1024), .BaseAddr(32'h0), .WaitStates(2)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one zero-wait transaction; the grant must come in the request cycle.
  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err);
    ifc0.req   = 1'b1;
    ifc0.we    = we;
    ifc0.be    = be;
    ifc0.addr  = addr;
    ifc0.wdata = wdata;
    @(negedge clk);
    chk("gnt0", 32'(ifc0.gnt), 32'd1);
    @(posedge clk);
    #1;
    q.push_back('{rdata: exp_rdata, err: exp_err});
  endtask

  task automatic idle0();
    ifc0.req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every response must arrive exactly one cycle after its grant.
  always @(negedge clk) begin
    if (ifc0.rvalid === 1'b1 || q.size() != 0) begin
      chk("rvalid0", 32'(ifc0.rvalid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("rdata0", ifc0.rdata, mon_e.rdata);
        chk("err0", 32'(ifc0.err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    rst = 1'b1;
    ifc0.req = 1'b1; ifc0.we = 1'b0; ifc0.be = 4'hF; ifc0.addr = '0; ifc0.wdata = '0;
    ifc2.req = 1'b0; ifc2.we = 1'b0; ifc2.be = 4'hF; ifc2.addr = '0; ifc2.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_gnt", 32'(ifc0.gnt), 32'd0);
    chk("rst_rvalid", 32'(ifc0.rvalid), 32'd0);
    chk("rst_err", 32'(ifc0.err), 32'd0);
    chk("rst_rdata", ifc0.rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle0();

    // Full-word write and read back
    issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    idle0();

    // Byte-enable merge
    issue(1'b1, 4'hF, 32'h20, 32'h11223344, 32'h0, 1'b0);
    issue(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h0, 1'b0);
    issue(1'b0, 4'h0, 32'h20, 32'h0, 32'h11BB33DD, 1'b0);
    idle0();

    // Out of range, and word 0 must not be aliased
    issue(1'b1, 4'hF, 32'h0, 32'h13579BDF, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h1000, 32'h0, 32'h0, 1'b1);
    issue(1'b1, 4'hF, 32'h1000, 32'hFFFFFFFF, 32'h0, 1'b1);
    issue(1'b0, 4'hF, 32'h0, 32'h0, 32'h13579BDF, 1'b0);
    idle0();

    // be=0 write leaves the word alone; low address bits ignored
    issue(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0);
    idle0();

    // Back-to-back with req held
    issue(1'b1, 4'hF, 32'h44, 32'hCAFEF00D, 32'h0, 1'b0);
    idle0();
    issue(1'b1, 4'hF, 32'h40, 32'h5, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h40, 32'h0, 32'h5, 1'b0);
    issue(1'b0, 4'hF, 32'h44, 32'h0, 32'hCAFEF00D, 1'b0);
    idle0();

    // Wait states: req held for six cycles grants in cycles 2 and 5
    ifc2.req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("ws_gnt_c%0d", c), 32'(ifc2.gnt), 32'((c == 2) || (c == 5)));
      chk($sformatf("ws_rvalid_c%0d", c), 32'(ifc2.rvalid), 32'(c == 3));
      if (c == 3) chk("ws_err", 32'(ifc2.err), 32'd0);
      @(posedge clk);
      #1;
    end
    ifc2.req = 1'b0;
    @(negedge clk);
    chk("ws_rvalid_c6", 32'(ifc2.rvalid), 32'd1);
    @(posedge clk);
    #1;

    // Wait states: dropping req restarts the count
    for (int c = 0; c < 6; c++) begin
      ifc2.req = (c != 1) && (c != 5);
      @(negedge clk);
      chk($sformatf("ws2_gnt_c%0d", c), 32'(ifc2.gnt), 32'(c == 4));
      chk($sformatf("ws2_rvalid_c%0d", c), 32'(ifc2.rvalid), 32'(c == 5));
      @(posedge clk);
      #1;
    end
    ifc2.req = 1'b0;

    // Reset right after a granted read; write requested during reset is blocked
    issue(1'b1, 4'hF, 32'h80, 32'h00000077, 32'h0, 1'b0);
    issue(1'b0, 4'hF, 32'h80, 32'h0, 32'h00000077, 1'b0);
    rst = 1'b1;
    ifc0.req = 1'b1; ifc0.we = 1'b1; ifc0.be = 4'hF; ifc0.addr = 32'h80; ifc0.wdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rstk_gnt", 32'(ifc0.gnt), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstk_rvalid", 32'(ifc0.rvalid), 32'd0);
    chk("rstk_err", 32'(ifc0.err), 32'd0);
    chk("rstk_rdata", ifc0.rdata, 32'h0);
    chk("rstk_gnt2", 32'(ifc0.gnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle0();
    issue(1'b0, 4'hF, 32'h80, 32'h0, 32'h00000077, 1'b0);
    idle0();
    idle0();

    chk("q_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
